// File: rtl/alu_seq_exec_if.sv
// alu_seq_exec_if: request/result bundle between a requester and the sequential ALU
interface alu_seq_exec_if #(parameter int N = 16);
  logic start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [2:0] aluOp;
  logic invA;
  logic invB;
  logic Cin;
  logic sign;
  logic rorSel;
  logic busy;
  logic done;
  logic [N-1:0] Out;
  logic Zero;
  logic Ofl;
  modport master (
    output start, A, B, aluOp, invA, invB, Cin, sign, rorSel,
    input  busy, done, Out, Zero, Ofl
  );
  modport slave (
    input  start, A, B, aluOp, invA, invB, Cin, sign, rorSel,
    output busy, done, Out, Zero, Ofl
  );
endinterface

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: single-cycle arithmetic/logic ops and bit-serial shifts/rotates with a done pulse
module alu_seq_exec #(parameter int N = 16) (
  input logic clk,
  input logic rst,
  alu_seq_exec_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [N-1:0] shiftReg;
  logic [3:0] cnt;
  logic [1:0] shOp;
  logic rorReg;
  logic [N-1:0] aEff;
  logic [N-1:0] bEff;
  logic [N:0] sum;
  logic [N-1:0] arith;
  logic arithOfl;
  logic [N-1:0] shNext;
  always_comb begin
    aEff = bus.invA ? ~bus.A : bus.A;
    bEff = bus.invB ? ~bus.B : bus.B;
    sum = {1'b0, aEff} + {1'b0, bEff} + (N+1)'(bus.Cin);
    arith = bus.aluOp[1:0] == 2'b00 ? sum[N-1:0] :
            bus.aluOp[1:0] == 2'b01 ? aEff & bEff :
            bus.aluOp[1:0] == 2'b10 ? aEff | bEff : aEff ^ bEff;
    // Only ADD can overflow; signed rule compares operand signs with the result sign
    arithOfl = bus.aluOp[1:0] != 2'b00 ? 1'b0 :
               bus.sign ? (aEff[N-1] == bEff[N-1] && sum[N-1] != aEff[N-1]) : sum[N];
    shNext = shOp == 2'b00 ? {shiftReg[N-2:0], shiftReg[N-1]} :
             shOp == 2'b01 ? (rorReg ? {shiftReg[0], shiftReg[N-1:1]} : {shiftReg[N-2:0], 1'b0}) :
             shOp == 2'b10 ? {shiftReg[N-1], shiftReg[N-1:1]} : {1'b0, shiftReg[N-1:1]};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      shiftReg <= '0;
      cnt <= '0;
      shOp <= '0;
      rorReg <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.Out <= '0;
      bus.Zero <= 1'b0;
      bus.Ofl <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE:
          if (bus.start) begin
            bus.busy <= 1'b1;
            shOp <= bus.aluOp[1:0];
            rorReg <= bus.rorSel;
            if (bus.aluOp[2]) begin
              bus.Out <= arith;
              bus.Zero <= arith == '0;
              bus.Ofl <= arithOfl;
              bus.done <= 1'b1;
              state <= DONE;
            end else if (bEff[3:0] == 4'd0) begin
              bus.Out <= aEff;
              bus.Zero <= aEff == '0;
              bus.Ofl <= 1'b0;
              bus.done <= 1'b1;
              state <= DONE;
            end else begin
              shiftReg <= aEff;
              cnt <= bEff[3:0];
              state <= SHIFT;
            end
          end
        SHIFT: begin
          shiftReg <= shNext;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            bus.Out <= shNext;
            bus.Zero <= shNext == '0;
            bus.Ofl <= 1'b0;
            bus.done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed vectors with hand-computed results for alu_seq_exec
module tb_alu_seq_exec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  alu_seq_exec_if #(.N(16)) bus ();
  alu_seq_exec #(.N(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic ia, input logic ib, input logic cin, input logic sgn, input logic ror,
                     input int lat, input logic [15:0] eOut, input logic eOfl, input logic poke);
    int cyc;
    bus.aluOp = op; bus.A = a; bus.B = b; bus.invA = ia; bus.invB = ib;
    bus.Cin = cin; bus.sign = sgn; bus.rorSel = ror; bus.start = 1'b1;
    tick();
    bus.start = poke;
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      if (poke) begin
        bus.A = 16'($urandom);
        bus.B = 16'($urandom);
        bus.aluOp = 3'($urandom);
      end
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, 32'(cyc), 32'(lat));
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
    chk({tag, "_out"}, 32'(bus.Out), 32'(eOut));
    chk({tag, "_zero"}, 32'(bus.Zero), 32'(eOut == 16'h0000));
    chk({tag, "_ofl"}, 32'(bus.Ofl), 32'(eOfl));
    tick();
    chk({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    chk({tag, "_hold"}, 32'(bus.Out), 32'(eOut));
  endtask
  initial begin
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.aluOp = '0;
    bus.invA = 1'b0; bus.invB = 1'b0; bus.Cin = 1'b0; bus.sign = 1'b0; bus.rorSel = 1'b0;
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_out", 32'(bus.Out), 32'd0);
    chk("rst_zero", 32'(bus.Zero), 32'd0);
    chk("rst_ofl", 32'(bus.Ofl), 32'd0);
    tick();
    rst = 1'b0;
    run("add_sovf", 3'b100, 16'h7FFF, 16'h0001, 0, 0, 0, 1, 0, 1, 16'h8000, 1, 0);
    run("ror4", 3'b001, 16'h0001, 16'h0004, 0, 0, 0, 0, 1, 5, 16'h1000, 0, 0);
    run("add_carry", 3'b100, 16'hFFFF, 16'h0001, 0, 0, 0, 0, 0, 1, 16'h0000, 1, 0);
    run("sra15", 3'b010, 16'h8000, 16'h000F, 0, 0, 0, 0, 0, 16, 16'hFFFF, 0, 1);
    repeat (3) begin
      tick();
      chk("sra_single_done", 32'(bus.done), 32'd0);
    end
    run("add_signed", 3'b100, 16'hFFFF, 16'h0001, 0, 0, 0, 1, 0, 1, 16'h0000, 0, 0);
    run("sub", 3'b100, 16'h0005, 16'h0005, 1, 0, 1, 1, 0, 1, 16'h0000, 0, 0);
    run("sll0", 3'b001, 16'h1234, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h1234, 0, 0);
    run("and", 3'b101, 16'hF0F0, 16'hFF00, 0, 0, 0, 0, 0, 1, 16'hF000, 0, 0);
    run("or", 3'b110, 16'hF0F0, 16'hFF00, 0, 0, 0, 0, 0, 1, 16'hFFF0, 0, 0);
    run("xor_invb", 3'b111, 16'hF0F0, 16'hFF00, 0, 1, 0, 0, 0, 1, 16'hF00F, 0, 0);
    run("rol3", 3'b000, 16'h8001, 16'h0003, 0, 0, 0, 0, 0, 4, 16'h000C, 0, 0);
    run("srl14_invb", 3'b011, 16'h8000, 16'hFFF1, 0, 1, 0, 0, 0, 15, 16'h0002, 0, 0);
    run("sll0_pre", 3'b001, 16'hABCD, 16'h0000, 0, 0, 0, 0, 0, 1, 16'hABCD, 0, 0);
    bus.aluOp = 3'b011; bus.A = 16'hFFFF; bus.B = 16'h0008; bus.invB = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("abort_in_shift", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_out", 32'(bus.Out), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_zero", 32'(bus.Zero), 32'd0);
    tick();
    rst = 1'b0;
    repeat (10) begin
      tick();
      chk("abort_no_done", 32'(bus.done), 32'd0);
    end
    run("post_rst_add", 3'b100, 16'h1234, 16'h0001, 0, 0, 0, 0, 0, 1, 16'h1235, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_seq_exec.md
ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

Interface
REQ-001 Parameter: N, 16, datapath width; only N=16 is required (shift count uses 4 bits).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request strobe; sampled only when busy=0.
REQ-005 A  input  N  operand A.
REQ-006 B  input  N  operand B; B[3:0] (after inversion) is the shift count for shift ops.
REQ-007 aluOp  input  3  op select: 000 ROL, 001 SLL (ROR when rorSel=1), 010 SRA, 011 SRL, 100 ADD, 101 AND, 110 OR, 111 XOR.
REQ-008 invA, invB  input  1 each  invert operand A / B before use.
REQ-009 Cin  input  1  carry-in for ADD.
REQ-010 sign  input  1  1 = signed overflow rule, 0 = unsigned (carry-out) rule.
REQ-011 rorSel  input  1  with aluOp=001, selects rotate right.
REQ-012 busy  output  1  high while an operation is in progress or being reported.
REQ-013 done  output  1  one-cycle pulse; Out/Zero/Ofl valid.
REQ-014 Out  output  N  registered result.
REQ-015 Zero  output  1  registered, Out==0.
REQ-016 Ofl  output  1  registered overflow/carry flag.

Function
REQ-017 Control inputs and operands SHALL be captured on the start edge; later changes have no effect on the operation in flight.
REQ-018 Effective operands: A' = invA ? ~A : A; B' = invB ? ~B : B.
REQ-019 FSM states IDLE, SHIFT, DONE; busy=0 only in IDLE.
REQ-020 IDLE + start + aluOp[2]=1: compute result combinationally from A', B', register into Out/Zero/Ofl, go DONE.
REQ-021 IDLE + start + aluOp[2]=0: load shift register with A', counter with B'[3:0]; count 0 -> Out=A', go DONE; else go SHIFT.
REQ-022 SHIFT: one bit position per cycle in the selected direction, counter decrements; after final position go DONE and register Out/Zero.
REQ-023 ROL/ROR wrap bits end-around; SLL/SRL fill 0; SRA replicates bit N-1.
REQ-024 DONE: done=1 exactly one cycle, then IDLE; done=0 in all other states.
REQ-025 Latency: start sampled at edge t -> done high in cycle t+1 for non-shift or count 0; t+1+count for shifts (max t+16).
REQ-026 ADD: Out = A'+B'+Cin modulo 2^N; Ofl = sign ? (A'[N-1]==B'[N-1] && Out[N-1]!=A'[N-1]) : carry-out.
REQ-027 AND/OR/XOR and all shifts: Ofl=0.
REQ-028 start while busy=1 SHALL be ignored (not queued); minimum spacing between accepted ops is 2 cycles.
REQ-029 Out/Zero/Ofl SHALL hold their last values until the next DONE update.

Reset
REQ-030 rst=1 forces IDLE immediately, regardless of clk: busy=0, done=0, Out=0, Zero=0, Ofl=0, counter=0.
REQ-031 rst asserted mid-operation aborts it; no done pulse is produced for the aborted op.
REQ-032 First start is accepted on the first rising edge with rst=0.

Verification
REQ-033 ADD A=0x7FFF B=0x0001 sign=1 Cin=0 -> done at t+1, Out=0x8000, Ofl=1, Zero=0.
REQ-034 ADD A=0xFFFF B=0x0001 sign=0 -> Out=0x0000, Zero=1, Ofl=1 (carry); sign=1 same operands -> Ofl=0.
REQ-035 Subtract: A=0x0005 B=0x0005 invA=1 Cin=1 aluOp=100 -> Out=0x0000, Zero=1, Ofl=0.
REQ-036 ROR A=0x0001 B=0x0004 aluOp=001 rorSel=1 -> done at t+5, Out=0x1000, busy high t+1..t+5.
REQ-037 SRA A=0x8000 B=0x000F with extra start pulses during busy -> single done at t+16, Out=0xFFFF; SLL count 0 -> done at t+1, Out=A.
REQ-038 rst pulsed during SHIFT of SRL A=0xFFFF B=8 -> busy=0, Out=0 immediately, no done; new start afterwards completes normally.
